regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between three producers: pipeline writeback (WB), jump-and-link return-address write (LINK) and the HI/LO-move/syscall result path (AUX). Each producer has a one-entry holding slot with a valid/ready handshake. A fixed-priority arbiter with starvation override drives one registered write per cycle into the register file. It also exports a pending-write scoreboard that decode uses for stalls.

Parameters:
STARVE_LIMIT, 4, wait cycles after which a held LINK/AUX entry overrides fixed priority (1..15)
NUM_REGS, 32, architectural registers; fixes scoreboard width and address width log2(NUM_REGS)=5

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
wb_valid  in  1  WB write request
wb_ready  out  1  WB slot can accept
wb_addr  in  5  WB destination register
wb_data  in  32  WB write data
link_valid  in  1  LINK request (destination fixed to r31)
link_ready  out  1  LINK slot can accept
link_data  in  32  PC+4 to store in r31
aux_valid  in  1  AUX write request
aux_ready  out  1  AUX slot can accept
aux_addr  in  5  AUX destination
aux_data  in  32  AUX write data
wr_en  out  1  register-file write strobe (registered)
wr_addr  out  5  register-file write address (registered)
wr_data  out  32  register-file write data (registered)
pending_mask  out  32  bit r set while a write to r is held or on wr_*

Behaviour:
- Reset (clk edge with rst=1): all slots empty, wr_en=0, wr_addr=0, wr_data=0, wait counters=0, pending_mask=0. rst overrides every same-cycle handshake. Held writes are dropped, never flushed.
- Handshake: transfer occurs on an edge where X_valid && X_ready. A slot captures {addr,data}; LINK's addr is 31.
- X_ready = (slot empty || slot granted this cycle) && !conflict_X. This is combinational from state and X_addr.
- conflict_X = X_addr equals the addr of a held slot belonging to a different requester. This preserves per-register write order. Same-requester reuse is allowed, since that slot is FIFO order 1.
- Writes to r0: the handshake completes and the slot loads normally. At grant, wr_en stays 0. No bit is set in pending_mask.
- Grant, evaluated each cycle among full slots:
  - Starved LINK (wait counter == STARVE_LIMIT) first.
  - Then starved AUX.
  - Then WB > LINK > AUX.
  - Exactly one grant per cycle.
- Output: on the edge after grant, wr_en=1 (0 if addr==0), wr_addr/wr_data = granted slot. With no grant, wr_en=0 and wr_addr/wr_data hold their value. Latency from accepting handshake edge to wr_en visible = 1 cycle minimum.
- The granted slot empties on the same edge, unless a new handshake refills it on that edge.
- Wait counters (LINK, AUX):
  - Increment (saturate at STARVE_LIMIT) each cycle the slot is full and not granted.
  - Clear on grant or when empty.
- Back-to-back: a continuously valid single requester writes one register per cycle with no bubbles.
- pending_mask = OR of decoded full-slot addrs (nonzero) | decode(wr_addr) when wr_en. It is combinational from registered state.
- Simultaneous: all three slots full → three grants over three consecutive cycles, in priority order.

Optional Feature:
ARB_STATS_EN: when defined, adds output ports stat_wb, stat_link, stat_aux (32 each), counting issued wr_en per source, and stat_conflict (32), counting cycles with any valid request blocked by conflict_X. Counters wrap mod 2^32 and clear on rst. Undefined: ports and counters are absent and there is no behavioural difference.

Test Plan:
- Reset: assert rst for 2 cycles with all valids high → wr_en=0, all ready=1 after release, pending_mask=0.
- Single write: wb_addr=5, wb_data=0xDEADBEEF for 1 cycle → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; pending_mask bit5 set over those 2 cycles then clear.
- Three-way collision: WB(r3), LINK(0x400010), AUX(r4) on the same edge → writes r3, r31, r4 on consecutive cycles.
- Starvation: WB streams continuously, LINK held → LINK written once its waiting reaches STARVE_LIMIT=4 cycles; WB stalls one cycle.
- Ordering conflict: AUX holds r8 while WB offers r8 → wb_ready=0 until the AUX r8 write is granted. Final r8 write order is AUX then WB.
- r0 write: wb_addr=0 → wb_ready=1, no wr_en pulse, pending_mask stays 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter for WB, LINK and AUX producers with one-entry
// holding slots, starvation override and a pending-write scoreboard.
// Optional per-source statistics counters: define ARB_STATS_EN.
module regfile_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned NUM_REGS     = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wb_valid,
   output logic                        wb_ready,
   input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
   input  logic [31:0]                 wb_data,
   input  logic                        link_valid,
   output logic                        link_ready,
   input  logic [31:0]                 link_data,
   input  logic                        aux_valid,
   output logic                        aux_ready,
   input  logic [$clog2(NUM_REGS)-1:0] aux_addr,
   input  logic [31:0]                 aux_data,
   output logic                        wr_en,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [31:0]                 wr_data,
`ifdef ARB_STATS_EN
   output logic [31:0]                 stat_wb,
   output logic [31:0]                 stat_link,
   output logic [31:0]                 stat_aux,
   output logic [31:0]                 stat_conflict,
`endif
   output logic [NUM_REGS-1:0]         pending_mask
);
   localparam int unsigned   AW        = $clog2(NUM_REGS);
   localparam logic [AW-1:0] LINK_ADDR = AW'(NUM_REGS - 1);
   localparam logic [AW-1:0] ZERO_ADDR = '0;
   localparam logic [3:0]    LIMIT     = 4'(STARVE_LIMIT);

   logic          wb_full_q, wb_full_d, link_full_q, link_full_d, aux_full_q, aux_full_d;
   logic [AW-1:0] wb_addr_q, wb_addr_d, aux_addr_q, aux_addr_d;
   logic [31:0]   wb_data_q, wb_data_d, link_data_q, link_data_d, aux_data_q, aux_data_d;
   logic [3:0]    link_wait_q, link_wait_d, aux_wait_q, aux_wait_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          gnt_wb_s, gnt_link_s, gnt_aux_s;
   logic          conflict_wb_s, conflict_link_s, conflict_aux_s;
   logic          wb_acc_s, link_acc_s, aux_acc_s;

   // r0 never appears on the scoreboard
   function automatic logic [NUM_REGS-1:0] dec_reg(input logic en, input logic [AW-1:0] addr);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (en && (addr != ZERO_ADDR)) v[addr] = 1'b1;
      else v = '0;
      return v;
   endfunction

   // Grant: starved LINK, starved AUX, then fixed WB > LINK > AUX
   always_comb begin
      gnt_wb_s   = 1'b0;
      gnt_link_s = 1'b0;
      gnt_aux_s  = 1'b0;
      if (link_full_q && (link_wait_q == LIMIT)) gnt_link_s = 1'b1;
      else if (aux_full_q && (aux_wait_q == LIMIT)) gnt_aux_s = 1'b1;
      else if (wb_full_q) gnt_wb_s = 1'b1;
      else if (link_full_q) gnt_link_s = 1'b1;
      else if (aux_full_q) gnt_aux_s = 1'b1;
      else gnt_wb_s = 1'b0;
   end

   // Block a producer whose target is still held by another slot, keeping per-register order
   always_comb begin
      conflict_wb_s   = (link_full_q && (wb_addr == LINK_ADDR)) || (aux_full_q && (wb_addr == aux_addr_q));
      conflict_link_s = (wb_full_q && (wb_addr_q == LINK_ADDR)) || (aux_full_q && (aux_addr_q == LINK_ADDR));
      conflict_aux_s  = (wb_full_q && (aux_addr == wb_addr_q)) || (link_full_q && (aux_addr == LINK_ADDR));
      wb_ready        = (!wb_full_q || gnt_wb_s) && !conflict_wb_s;
      link_ready      = (!link_full_q || gnt_link_s) && !conflict_link_s;
      aux_ready       = (!aux_full_q || gnt_aux_s) && !conflict_aux_s;
      wb_acc_s        = wb_valid && wb_ready;
      link_acc_s      = link_valid && link_ready;
      aux_acc_s       = aux_valid && aux_ready;
   end

   // Slot refill/drain, wait counters and the write-port mux
   always_comb begin
      wb_full_d   = wb_acc_s || (wb_full_q && !gnt_wb_s);
      wb_addr_d   = wb_acc_s ? wb_addr : wb_addr_q;
      wb_data_d   = wb_acc_s ? wb_data : wb_data_q;
      link_full_d = link_acc_s || (link_full_q && !gnt_link_s);
      link_data_d = link_acc_s ? link_data : link_data_q;
      aux_full_d  = aux_acc_s || (aux_full_q && !gnt_aux_s);
      aux_addr_d  = aux_acc_s ? aux_addr : aux_addr_q;
      aux_data_d  = aux_acc_s ? aux_data : aux_data_q;
      link_wait_d = 4'd0;
      aux_wait_d  = 4'd0;
      if (link_full_q && !gnt_link_s) link_wait_d = (link_wait_q == LIMIT) ? LIMIT : link_wait_q + 4'd1;
      else link_wait_d = 4'd0;
      if (aux_full_q && !gnt_aux_s) aux_wait_d = (aux_wait_q == LIMIT) ? LIMIT : aux_wait_q + 4'd1;
      else aux_wait_d = 4'd0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (gnt_wb_s) begin
         wr_en_d   = (wb_addr_q != ZERO_ADDR);
         wr_addr_d = wb_addr_q;
         wr_data_d = wb_data_q;
      end else if (gnt_link_s) begin
         wr_en_d   = 1'b1;
         wr_addr_d = LINK_ADDR;
         wr_data_d = link_data_q;
      end else if (gnt_aux_s) begin
         wr_en_d   = (aux_addr_q != ZERO_ADDR);
         wr_addr_d = aux_addr_q;
         wr_data_d = aux_data_q;
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // State registers; reset drops any held writes
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_full_q   <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= 32'd0;
         link_full_q <= 1'b0;
         link_data_q <= 32'd0;
         aux_full_q  <= 1'b0;
         aux_addr_q  <= '0;
         aux_data_q  <= 32'd0;
         link_wait_q <= 4'd0;
         aux_wait_q  <= 4'd0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 32'd0;
      end else begin
         wb_full_q   <= wb_full_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         link_full_q <= link_full_d;
         link_data_q <= link_data_d;
         aux_full_q  <= aux_full_d;
         aux_addr_q  <= aux_addr_d;
         aux_data_q  <= aux_data_d;
         link_wait_q <= link_wait_d;
         aux_wait_q  <= aux_wait_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign pending_mask = dec_reg(wb_full_q, wb_addr_q) | dec_reg(link_full_q, LINK_ADDR)
                       | dec_reg(aux_full_q, aux_addr_q) | dec_reg(wr_en_q, wr_addr_q);

`ifdef ARB_STATS_EN
   logic [31:0] stat_wb_q, stat_wb_d, stat_link_q, stat_link_d;
   logic [31:0] stat_aux_q, stat_aux_d, stat_conflict_q, stat_conflict_d;

   // Counters advance on the edge that issues the counted write
   always_comb begin
      stat_wb_d       = stat_wb_q + ((gnt_wb_s && (wb_addr_q != ZERO_ADDR)) ? 32'd1 : 32'd0);
      stat_link_d     = stat_link_q + (gnt_link_s ? 32'd1 : 32'd0);
      stat_aux_d      = stat_aux_q + ((gnt_aux_s && (aux_addr_q != ZERO_ADDR)) ? 32'd1 : 32'd0);
      stat_conflict_d = stat_conflict_q +
                        (((wb_valid && conflict_wb_s) || (link_valid && conflict_link_s) ||
                          (aux_valid && conflict_aux_s)) ? 32'd1 : 32'd0);
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_wb_q       <= 32'd0;
         stat_link_q     <= 32'd0;
         stat_aux_q      <= 32'd0;
         stat_conflict_q <= 32'd0;
      end else begin
         stat_wb_q       <= stat_wb_d;
         stat_link_q     <= stat_link_d;
         stat_aux_q      <= stat_aux_d;
         stat_conflict_q <= stat_conflict_d;
      end
   end

   assign stat_wb       = stat_wb_q;
   assign stat_link     = stat_link_q;
   assign stat_aux      = stat_aux_q;
   assign stat_conflict = stat_conflict_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a slot-level model.
module tb_regfile_write_arbiter;
   localparam int LIMIT = 4;

   logic        clk, rst;
   logic        wb_valid, wb_ready, link_valid, link_ready, aux_valid, aux_ready;
   logic [4:0]  wb_addr, aux_addr, wr_addr;
   logic [31:0] wb_data, link_data, aux_data, wr_data, pending_mask;
   logic        wr_en;

   int tests = 0;
   int fails = 0;

   regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .link_valid(link_valid), .link_ready(link_ready), .link_data(link_data),
      .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending_mask(pending_mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: source 0=WB, 1=LINK, 2=AUX; each a held {addr,data} entry plus a wait count
   bit          m_live = 1'b0;
   bit          m_full[3];
   logic [4:0]  m_addr[3];
   logic [31:0] m_data[3];
   int          m_wait[3];
   logic        m_wr_en;
   logic [4:0]  m_wr_addr;
   logic [31:0] m_wr_data;

   function automatic int m_pick();
      if (m_full[1] && m_wait[1] == LIMIT) return 1;
      if (m_full[2] && m_wait[2] == LIMIT) return 2;
      for (int s = 0; s < 3; s++) if (m_full[s]) return s;
      return -1;
   endfunction

   function automatic logic [4:0] in_addr(input int s);
      case (s)
         0:       return wb_addr;
         1:       return 5'd31;
         default: return aux_addr;
      endcase
   endfunction

   function automatic logic [31:0] in_data(input int s);
      case (s)
         0:       return wb_data;
         1:       return link_data;
         default: return aux_data;
      endcase
   endfunction

   function automatic bit in_valid(input int s);
      case (s)
         0:       return wb_valid;
         1:       return link_valid;
         default: return aux_valid;
      endcase
   endfunction

   function automatic bit m_ready(input int s);
      bit blocked = 1'b0;
      for (int o = 0; o < 3; o++)
         if (o != s && m_full[o] && m_addr[o] == in_addr(s)) blocked = 1'b1;
      return (!m_full[s] || m_pick() == s) && !blocked;
   endfunction

   function automatic logic [31:0] m_pending();
      logic [31:0] p = 32'd0;
      for (int s = 0; s < 3; s++)
         if (m_full[s] && m_addr[s] != 5'd0) p[m_addr[s]] = 1'b1;
      if (m_wr_en) p[m_wr_addr] = 1'b1;
      return p;
   endfunction

   initial begin : model_advance
      forever begin
         int g;
         bit acc[3];
         @(posedge clk);
         if (rst) begin
            for (int s = 0; s < 3; s++) begin
               m_full[s] = 1'b0; m_addr[s] = 5'd0; m_data[s] = 32'd0; m_wait[s] = 0;
            end
            m_wr_en = 1'b0; m_wr_addr = 5'd0; m_wr_data = 32'd0;
            m_live = 1'b1;
         end else if (m_live) begin
            g = m_pick();
            for (int s = 0; s < 3; s++) acc[s] = in_valid(s) && m_ready(s);
            if (g >= 0) begin
               m_wr_en = (m_addr[g] != 5'd0); m_wr_addr = m_addr[g]; m_wr_data = m_data[g];
            end else begin
               m_wr_en = 1'b0;
            end
            for (int s = 0; s < 3; s++) begin
               if (acc[s]) begin
                  m_full[s] = 1'b1; m_addr[s] = in_addr(s); m_data[s] = in_data(s); m_wait[s] = 0;
               end else if (g == s || !m_full[s]) begin
                  m_full[s] = 1'b0; m_wait[s] = 0;
               end else begin
                  m_wait[s] = (m_wait[s] < LIMIT) ? m_wait[s] + 1 : LIMIT;
               end
            end
         end
      end
   end

   initial begin : compare_proc
      forever begin
         @(negedge clk);
         if (m_live) begin
            chk("cyc_wr_en", 64'(wr_en), 64'(m_wr_en));
            chk("cyc_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
            chk("cyc_wr_data", 64'(wr_data), 64'(m_wr_data));
            chk("cyc_wb_ready", 64'(wb_ready), 64'(m_ready(0)));
            chk("cyc_link_ready", 64'(link_ready), 64'(m_ready(1)));
            chk("cyc_aux_ready", 64'(aux_ready), 64'(m_ready(2)));
            chk("cyc_pending", 64'(pending_mask), 64'(m_pending()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return 5'd0;
         1:       return 5'd31;
         default: return 5'($urandom_range(1, 4));
      endcase
   endfunction

   initial begin : stimulus
      int link_at, stalls;
      logic [31:0] link_seen;
      rst = 1'b1;
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1;
      link_valid = 1'b1; link_data = 32'h2;
      aux_valid = 1'b1; aux_addr = 5'd9; aux_data = 32'h3;
      step(); step();
      rst = 1'b0; wb_valid = 1'b0; link_valid = 1'b0; aux_valid = 1'b0;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_ready", 64'({wb_ready, link_ready, aux_ready}), 64'd7);
      chk("rst_pending", 64'(pending_mask), 64'd0);

      // single write
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      step(); wb_valid = 1'b0;
      chk("single_held_pending", 64'(pending_mask), 64'h20);
      chk("single_held_wr_en", 64'(wr_en), 64'd0);
      step();
      chk("single_wr", 64'({wr_en, wr_addr, wr_data}), {27'd0, 1'b1, 5'd5, 32'hDEADBEEF});
      chk("single_wr_pending", 64'(pending_mask), 64'h20);
      step();
      chk("single_after", 64'({wr_en, pending_mask}), 64'd0);

      // three-way collision
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
      link_valid = 1'b1; link_data = 32'h0040_0010;
      aux_valid = 1'b1; aux_addr = 5'd4; aux_data = 32'h44;
      step(); wb_valid = 1'b0; link_valid = 1'b0; aux_valid = 1'b0;
      chk("coll_pending", 64'(pending_mask), 64'h8000_0018);
      step(); chk("coll_1", 64'({wr_en, wr_addr, wr_data}), {27'd0, 1'b1, 5'd3, 32'h33});
      step(); chk("coll_2", 64'({wr_en, wr_addr, wr_data}), {27'd0, 1'b1, 5'd31, 32'h0040_0010});
      step(); chk("coll_3", 64'({wr_en, wr_addr, wr_data}), {27'd0, 1'b1, 5'd4, 32'h44});
      step(); chk("coll_idle", 64'(wr_en), 64'd0);

      // starvation: WB streams while one LINK entry waits
      wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1000;
      link_valid = 1'b1; link_data = 32'h0040_0020;
      step(); link_valid = 1'b0;
      link_at = 0; stalls = 0; link_seen = 32'd0;
      for (int k = 1; k <= 8; k++) begin
         wb_data = 32'h1000 + 32'(k);
         step();
         if (wr_en && wr_addr == 5'd31 && link_at == 0) begin
            link_at = k; link_seen = wr_data;
         end
         if (!wb_ready) stalls++;
      end
      wb_valid = 1'b0;
      chk("starve_link_cycle", 64'(link_at), 64'd5);
      chk("starve_link_data", 64'(link_seen), 64'h0040_0020);
      chk("starve_wb_stalls", 64'(stalls), 64'd1);
      repeat (4) step();

      // ordering conflict on r8
      link_valid = 1'b1; link_data = 32'h500;
      aux_valid = 1'b1; aux_addr = 5'd8; aux_data = 32'hAA;
      step(); link_valid = 1'b0; aux_valid = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'hBB;
      #1 chk("order_block_1", 64'(wb_ready), 64'd0);
      step(); chk("order_block_2", 64'(wb_ready), 64'd0);
      step();
      chk("order_aux_first", 64'({wr_en, wr_addr, wr_data}), {27'd0, 1'b1, 5'd8, 32'hAA});
      chk("order_unblock", 64'(wb_ready), 64'd1);
      step(); wb_valid = 1'b0;
      step();
      chk("order_wb_second", 64'({wr_en, wr_addr, wr_data}), {27'd0, 1'b1, 5'd8, 32'hBB});
      step();

      // write to r0
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h123;
      #1 chk("r0_ready", 64'(wb_ready), 64'd1);
      step(); wb_valid = 1'b0;
      chk("r0_held", 64'({wr_en, pending_mask}), 64'd0);
      step();
      chk("r0_grant", 64'({wr_en, pending_mask}), 64'd0);
      step();

      // randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 499) == 0);
         wb_valid   = ($urandom_range(0, 99) < 60);
         wb_addr    = rand_addr();
         wb_data    = $urandom;
         link_valid = ($urandom_range(0, 99) < 30);
         link_data  = $urandom;
         aux_valid  = ($urandom_range(0, 99) < 40);
         aux_addr   = rand_addr();
         aux_data   = $urandom;
         step();
      end
      rst = 1'b0; wb_valid = 1'b0; link_valid = 1'b0; aux_valid = 1'b0;
      repeat (8) step();
      chk("drain_idle", 64'({wr_en, pending_mask}), 64'd0);
      chk("drain_ready", 64'({wb_ready, link_ready, aux_ready}), 64'd7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
